// File: rtl/trigger_pkg.sv
// Shared types and width helpers for the trigger sequencer.
// Imported by the interface, match stage and top.
package trigger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // max(1, clog2(n)) so single-entry selectors still have one bit
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int stage_w(input int num_stages);
        return width_of(num_stages);
    endfunction

    function automatic int ch_w(input int sample_width);
        return width_of(sample_width);
    endfunction

endpackage

// File: rtl/trigger_sequencer_if.sv
// Bundle carrying the current stage's config and sample history to
// the match logic, and the edge/pattern verdicts back.
interface trigger_sequencer_if #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int CH_W         = 3
);
    logic [SAMPLE_WIDTH-1:0] sample;
    logic [SAMPLE_WIDTH-1:0] prevSample;
    logic                    prevValid;
    logic [SAMPLE_WIDTH-1:0] activeChannels;
    logic                    edgeEnable;
    logic                    edgeType;
    logic [CH_W-1:0]         edgeChannel;
    logic                    patternEnable;
    logic [SAMPLE_WIDTH-1:0] pattern;
    logic [SAMPLE_WIDTH-1:0] dontCare;
    logic                    edgeOk;
    logic                    patternOk;

    modport master (
        output sample, prevSample, prevValid, activeChannels,
        output edgeEnable, edgeType, edgeChannel,
        output patternEnable, pattern, dontCare,
        input  edgeOk, patternOk
    );

    modport slave (
        input  sample, prevSample, prevValid, activeChannels,
        input  edgeEnable, edgeType, edgeChannel,
        input  patternEnable, pattern, dontCare,
        output edgeOk, patternOk
    );
endinterface

// File: rtl/trigger_stage_match.sv
// Combinational edge and pattern check for one stage's config.
// A channel index beyond the sample width never reports an edge.
module trigger_stage_match #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int CH_W         = 3
) (
    trigger_sequencer_if.slave m
);
    logic curBit;
    logic prevBit;
    logic chValid;

    // Pick the monitored channel, flagging indices that do not exist
    always_comb begin
        curBit  = 1'b0;
        prevBit = 1'b0;
        chValid = 1'b0;
        for (int i = 0; i < SAMPLE_WIDTH; i++) begin
            if (int'(m.edgeChannel) == i) begin
                curBit  = m.sample[i];
                prevBit = m.prevSample[i];
                chValid = 1'b1;
            end
        end
    end

    assign m.edgeOk = ~m.edgeEnable |
        (chValid & m.prevValid &
         (m.edgeType ? (curBit & ~prevBit) : (~curBit & prevBit)));

    assign m.patternOk = ~m.patternEnable |
        (&(~m.activeChannels | m.dontCare | ~(m.sample ^ m.pattern)));

endmodule

// File: rtl/trigger_sequencer.sv
// Multi-stage logic-analyser trigger: walks configured edge/pattern
// stages with per-stage match counts and fires a one-cycle trigger.
module trigger_sequencer
    import trigger_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 8,
    parameter int NUM_STAGES   = 4,
    parameter int COUNT_WIDTH  = 16,
    localparam int STAGE_W     = stage_w(NUM_STAGES),
    localparam int CH_W        = ch_w(SAMPLE_WIDTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sampleValid,
    input  logic [SAMPLE_WIDTH-1:0]           sample,
    input  logic [SAMPLE_WIDTH-1:0]           activeChannels,
    input  logic                              arm,
    input  logic                              disarm,
    input  logic [STAGE_W-1:0]                lastStage,
    input  logic [NUM_STAGES-1:0]             cfgEdgeEnable,
    input  logic [NUM_STAGES-1:0]             cfgEdgeType,
    input  logic [NUM_STAGES-1:0]             cfgPatternEnable,
    input  logic [NUM_STAGES*CH_W-1:0]        cfgEdgeChannel,
    input  logic [NUM_STAGES*SAMPLE_WIDTH-1:0] cfgPattern,
    input  logic [NUM_STAGES*SAMPLE_WIDTH-1:0] cfgDontCare,
    input  logic [NUM_STAGES*COUNT_WIDTH-1:0] cfgMatchCount,
    output logic                              triggered,
    output logic                              transition,
    output logic                              armed,
    output logic                              done,
    output logic [STAGE_W-1:0]                stage,
    output logic [1:0]                        state
);
    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_RUNNING = ST_RUNNING;
    localparam logic [1:0] S_DONE    = ST_DONE;
    localparam int         LAST_IDX  = NUM_STAGES - 1;

    logic [1:0]              state_q, state_d;
    logic [STAGE_W-1:0]      stage_q, stage_d;
    logic [COUNT_WIDTH-1:0]  hit_q, hit_d;
    logic [SAMPLE_WIDTH-1:0] prev_q, prev_d;
    logic                    prevValid_q, prevValid_d;
    logic                    trig_q, trig_d;
    logic                    trans_q, trans_d;
    logic                    done_q, done_d;

    int                      idx;
    logic [COUNT_WIDTH-1:0]  reqRaw;
    logic [COUNT_WIDTH-1:0]  reqEff;
    logic [COUNT_WIDTH:0]    hitNext;
    logic                    countMet;
    logic [STAGE_W-1:0]      finalStage;
    logic                    atFinal;
    logic                    match;

    trigger_sequencer_if #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .CH_W         (CH_W)
    ) mif ();

    assign idx = int'(stage_q);

    assign mif.sample         = sample;
    assign mif.prevSample     = prev_q;
    assign mif.prevValid      = prevValid_q;
    assign mif.activeChannels = activeChannels;
    assign mif.edgeEnable     = cfgEdgeEnable[idx];
    assign mif.edgeType       = cfgEdgeType[idx];
    assign mif.edgeChannel    = cfgEdgeChannel[idx*CH_W +: CH_W];
    assign mif.patternEnable  = cfgPatternEnable[idx];
    assign mif.pattern        = cfgPattern[idx*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    assign mif.dontCare       = cfgDontCare[idx*SAMPLE_WIDTH +: SAMPLE_WIDTH];

    trigger_stage_match #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .CH_W         (CH_W)
    ) u_match (
        .m (mif.slave)
    );

    assign match    = sampleValid & mif.edgeOk & mif.patternOk;
    assign reqRaw   = cfgMatchCount[idx*COUNT_WIDTH +: COUNT_WIDTH];
    assign reqEff   = (reqRaw == '0) ? COUNT_WIDTH'(1) : reqRaw;
    assign hitNext  = {1'b0, hit_q} + (COUNT_WIDTH+1)'(1);
    assign countMet = hitNext >= {1'b0, reqEff};

    // Clamp an out-of-range final-stage index to the last real stage
    always_comb begin
        finalStage = lastStage;
        if (int'(lastStage) >= LAST_IDX) begin
            finalStage = STAGE_W'(LAST_IDX);
        end
    end

    assign atFinal = stage_q == finalStage;

    // Next-state: history tracking, transition detect and stage walk
    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        hit_d       = hit_q;
        prev_d      = prev_q;
        prevValid_d = prevValid_q;
        trig_d      = 1'b0;
        done_d      = done_q;
        trans_d     = sampleValid & prevValid_q &
                      (|(activeChannels & (sample ^ prev_q)));

        if (sampleValid) begin
            prev_d      = sample;
            prevValid_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (arm && !disarm) begin
                    state_d = S_RUNNING;
                    stage_d = '0;
                    hit_d   = '0;
                    done_d  = 1'b0;
                end
            end
            S_RUNNING: begin
                if (disarm) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end else if (arm) begin
                    stage_d = '0;
                    hit_d   = '0;
                end else if (match) begin
                    if (countMet) begin
                        hit_d = '0;
                        if (atFinal) begin
                            state_d = S_DONE;
                            trig_d  = 1'b1;
                            done_d  = 1'b1;
                        end else begin
                            stage_d = stage_q + STAGE_W'(1);
                        end
                    end else if (hit_q != '1) begin
                        hit_d = hit_q + COUNT_WIDTH'(1);
                    end
                end
            end
            S_DONE: begin
                if (disarm) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end else if (arm) begin
                    state_d = S_RUNNING;
                    stage_d = '0;
                    hit_d   = '0;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                stage_d = '0;
                hit_d   = '0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset overriding all inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            stage_q     <= '0;
            hit_q       <= '0;
            prev_q      <= '0;
            prevValid_q <= 1'b0;
            trig_q      <= 1'b0;
            trans_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            hit_q       <= hit_d;
            prev_q      <= prev_d;
            prevValid_q <= prevValid_d;
            trig_q      <= trig_d;
            trans_q     <= trans_d;
            done_q      <= done_d;
        end
    end

    assign triggered  = trig_q;
    assign transition = trans_q;
    assign armed      = state_q == S_RUNNING;
    assign done       = done_q;
    assign stage      = stage_q;
    assign state      = state_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer (8 channels, 4 stages) plus a
// standalone 6-channel match stage for out-of-range edge channels.
module tb_trigger_sequencer;
    logic        clk;
    logic        rst;
    logic        sampleValid;
    logic [7:0]  sample;
    logic [7:0]  activeChannels;
    logic        arm;
    logic        disarm;
    logic [1:0]  lastStage;
    logic [3:0]  cfgEdgeEnable;
    logic [3:0]  cfgEdgeType;
    logic [3:0]  cfgPatternEnable;
    logic [11:0] cfgEdgeChannel;
    logic [31:0] cfgPattern;
    logic [31:0] cfgDontCare;
    logic [63:0] cfgMatchCount;
    logic        triggered;
    logic        transition;
    logic        armed;
    logic        done;
    logic [1:0]  stage;
    logic [1:0]  state;

    int checks;
    int failures;

    trigger_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .sampleValid      (sampleValid),
        .sample           (sample),
        .activeChannels   (activeChannels),
        .arm              (arm),
        .disarm           (disarm),
        .lastStage        (lastStage),
        .cfgEdgeEnable    (cfgEdgeEnable),
        .cfgEdgeType      (cfgEdgeType),
        .cfgPatternEnable (cfgPatternEnable),
        .cfgEdgeChannel   (cfgEdgeChannel),
        .cfgPattern       (cfgPattern),
        .cfgDontCare      (cfgDontCare),
        .cfgMatchCount    (cfgMatchCount),
        .triggered        (triggered),
        .transition       (transition),
        .armed            (armed),
        .done             (done),
        .stage            (stage),
        .state            (state)
    );

    trigger_sequencer_if #(.SAMPLE_WIDTH(6), .CH_W(3)) tif ();

    trigger_stage_match #(.SAMPLE_WIDTH(6), .CH_W(3)) u_sm (
        .m (tif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc(input logic v, input logic [7:0] s);
        sampleValid = v;
        sample      = s;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_clear();
        activeChannels   = 8'hFF;
        lastStage        = 2'd0;
        cfgEdgeEnable    = '0;
        cfgEdgeType      = '0;
        cfgPatternEnable = '0;
        cfgEdgeChannel   = '0;
        cfgPattern       = '0;
        cfgDontCare      = '0;
        cfgMatchCount    = '0;
    endtask

    task automatic set_edge(input int st, input logic rise, input logic [2:0] ch);
        cfgEdgeEnable[st]         = 1'b1;
        cfgEdgeType[st]           = rise;
        cfgEdgeChannel[st*3 +: 3] = ch;
    endtask

    task automatic set_pat(input int st, input logic [7:0] p, input logic [15:0] n);
        cfgPatternEnable[st]       = 1'b1;
        cfgPattern[st*8 +: 8]      = p;
        cfgMatchCount[st*16 +: 16] = n;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        arm    = 1'b0;
        disarm = 1'b0;
        cyc(1'b0, 8'h00);
        rst    = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        arm    = 1'b1;
        disarm = 1'b0;
        cyc(1'b1, 8'hFF);
        cyc(1'b1, 8'h00);
        checks++;
        if ({triggered, transition, armed, done, stage, state} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outs got=%b exp=00000000",
                {triggered, transition, armed, done, stage, state});
        end
        rst = 1'b0;
        arm = 1'b0;
    endtask

    task automatic test_sequence();
        cfg_clear();
        set_edge(0, 1'b1, 3'd2);
        set_pat(1, 8'hA5, 16'd0);
        set_edge(2, 1'b0, 3'd2);
        lastStage = 2'd2;
        do_reset();
        cyc(1'b1, 8'h00);
        arm = 1'b1;
        cyc(1'b1, 8'h00);
        arm = 1'b0;
        checks++;
        if (armed !== 1'b1 || state !== 2'd1 || stage !== 2'd0) begin
            failures++;
            $display("FAIL seq_arm armed=%b state=%0d stage=%0d exp 1/1/0", armed, state, stage);
        end
        cyc(1'b1, 8'h04);
        checks++;
        if (stage !== 2'd1 || transition !== 1'b1) begin
            failures++;
            $display("FAIL seq_rise stage=%0d trans=%b exp 1/1", stage, transition);
        end
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'hA5);
        checks++;
        if (stage !== 2'd2) begin
            failures++;
            $display("FAIL seq_pat stage=%0d exp=2", stage);
        end
        cyc(1'b0, 8'h00);
        checks++;
        if (stage !== 2'd2 || triggered !== 1'b0 || transition !== 1'b0) begin
            failures++;
            $display("FAIL seq_idle stage=%0d trig=%b trans=%b exp 2/0/0", stage, triggered, transition);
        end
        cyc(1'b1, 8'hA1);
        checks++;
        if (triggered !== 1'b1 || done !== 1'b1 || state !== 2'd2 || armed !== 1'b0 || stage !== 2'd2) begin
            failures++;
            $display("FAIL seq_fire trig=%b done=%b state=%0d armed=%b stage=%0d exp 1/1/2/0/2",
                triggered, done, state, armed, stage);
        end
        cyc(1'b1, 8'hA1);
        checks++;
        if (triggered !== 1'b0 || done !== 1'b1 || state !== 2'd2) begin
            failures++;
            $display("FAIL seq_hold trig=%b done=%b state=%0d exp 0/1/2", triggered, done, state);
        end
    endtask

    task automatic test_match_count();
        cfg_clear();
        set_pat(0, 8'h0F, 16'd3);
        set_pat(1, 8'hFF, 16'd1);
        lastStage = 2'd1;
        do_reset();
        arm = 1'b1;
        cyc(1'b1, 8'h00);
        arm = 1'b0;
        cyc(1'b1, 8'h0F);
        cyc(1'b1, 8'h0F);
        checks++;
        if (stage !== 2'd0) begin
            failures++;
            $display("FAIL cnt_two stage=%0d exp=0", stage);
        end
        cyc(1'b0, 8'h0F);
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'h11);
        checks++;
        if (stage !== 2'd0 || armed !== 1'b1) begin
            failures++;
            $display("FAIL cnt_miss stage=%0d armed=%b exp 0/1", stage, armed);
        end
        cyc(1'b1, 8'h0F);
        checks++;
        if (stage !== 2'd1 || triggered !== 1'b0) begin
            failures++;
            $display("FAIL cnt_third stage=%0d trig=%b exp 1/0", stage, triggered);
        end
    endtask

    task automatic test_restart();
        cfg_clear();
        set_pat(0, 8'h55, 16'd1);
        do_reset();
        arm = 1'b1;
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'h55);
        arm = 1'b0;
        checks++;
        if (triggered !== 1'b0 || state !== 2'd1) begin
            failures++;
            $display("FAIL rst_arm_ignore trig=%b state=%0d exp 0/1", triggered, state);
        end
        cyc(1'b1, 8'h55);
        checks++;
        if (triggered !== 1'b1 || state !== 2'd2) begin
            failures++;
            $display("FAIL restart_fire trig=%b state=%0d exp 1/2", triggered, state);
        end
        arm = 1'b1;
        cyc(1'b1, 8'h00);
        arm = 1'b0;
        checks++;
        if (state !== 2'd1 || done !== 1'b0 || stage !== 2'd0) begin
            failures++;
            $display("FAIL rearm_done state=%0d done=%b stage=%0d exp 1/0/0", state, done, stage);
        end
    endtask

    task automatic test_abort();
        cfg_clear();
        set_pat(0, 8'h55, 16'd1);
        do_reset();
        arm = 1'b1;
        cyc(1'b1, 8'h00);
        disarm = 1'b1;
        cyc(1'b1, 8'h55);
        checks++;
        if (state !== 2'd0 || triggered !== 1'b0 || armed !== 1'b0) begin
            failures++;
            $display("FAIL abort_both state=%0d trig=%b armed=%b exp 0/0/0", state, triggered, armed);
        end
        disarm = 1'b0;
        cyc(1'b1, 8'h00);
        arm = 1'b0;
        disarm = 1'b1;
        cyc(1'b1, 8'h55);
        disarm = 1'b0;
        checks++;
        if (state !== 2'd0 || triggered !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_final state=%0d trig=%b done=%b exp 0/0/0", state, triggered, done);
        end
        arm = 1'b1;
        cyc(1'b1, 8'h00);
        arm = 1'b0;
        cyc(1'b1, 8'h55);
        disarm = 1'b1;
        cyc(1'b1, 8'h00);
        disarm = 1'b0;
        checks++;
        if (state !== 2'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_done state=%0d done=%b exp 0/0", state, done);
        end
    endtask

    task automatic test_transition();
        cfg_clear();
        activeChannels = 8'h0F;
        do_reset();
        cyc(1'b1, 8'h10);
        checks++;
        if (transition !== 1'b0) begin
            failures++;
            $display("FAIL trans_first got=%b exp=0", transition);
        end
        cyc(1'b1, 8'h30);
        checks++;
        if (transition !== 1'b0) begin
            failures++;
            $display("FAIL trans_masked got=%b exp=0", transition);
        end
        cyc(1'b1, 8'h31);
        checks++;
        if (transition !== 1'b1) begin
            failures++;
            $display("FAIL trans_pulse got=%b exp=1", transition);
        end
        cyc(1'b1, 8'h31);
        checks++;
        if (transition !== 1'b0) begin
            failures++;
            $display("FAIL trans_clear got=%b exp=0", transition);
        end
    endtask

    task automatic test_reset_mid();
        cfg_clear();
        set_pat(0, 8'h01, 16'd1);
        set_pat(1, 8'h02, 16'd3);
        lastStage = 2'd2;
        do_reset();
        arm = 1'b1;
        cyc(1'b1, 8'h00);
        arm = 1'b0;
        cyc(1'b1, 8'h01);
        cyc(1'b1, 8'h02);
        cyc(1'b1, 8'h02);
        checks++;
        if (stage !== 2'd1 || armed !== 1'b1) begin
            failures++;
            $display("FAIL mid_stage stage=%0d armed=%b exp 1/1", stage, armed);
        end
        rst = 1'b1;
        cyc(1'b1, 8'h01);
        rst = 1'b0;
        checks++;
        if ({triggered, transition, armed, done, stage, state} !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset got=%b exp=00000000",
                {triggered, transition, armed, done, stage, state});
        end
        cfg_clear();
        set_edge(0, 1'b1, 3'd0);
        arm = 1'b1;
        cyc(1'b0, 8'h00);
        arm = 1'b0;
        cyc(1'b1, 8'h01);
        checks++;
        if (triggered !== 1'b0 || state !== 2'd1) begin
            failures++;
            $display("FAIL mid_noprev trig=%b state=%0d exp 0/1", triggered, state);
        end
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'h01);
        checks++;
        if (triggered !== 1'b1) begin
            failures++;
            $display("FAIL mid_edge trig=%b exp=1", triggered);
        end
    endtask

    task automatic test_edge_range();
        tif.prevValid      = 1'b1;
        tif.prevSample     = 6'h00;
        tif.sample         = 6'h3F;
        tif.activeChannels = 6'h3F;
        tif.edgeEnable     = 1'b1;
        tif.edgeType       = 1'b1;
        tif.edgeChannel    = 3'd7;
        tif.patternEnable  = 1'b0;
        tif.pattern        = 6'h00;
        tif.dontCare       = 6'h00;
        #1;
        checks++;
        if (tif.edgeOk !== 1'b0) begin
            failures++;
            $display("FAIL sm_ch7 edgeOk=%b exp=0", tif.edgeOk);
        end
        tif.edgeChannel = 3'd6;
        #1;
        checks++;
        if (tif.edgeOk !== 1'b0) begin
            failures++;
            $display("FAIL sm_ch6 edgeOk=%b exp=0", tif.edgeOk);
        end
        tif.edgeChannel = 3'd5;
        #1;
        checks++;
        if (tif.edgeOk !== 1'b1) begin
            failures++;
            $display("FAIL sm_ch5 edgeOk=%b exp=1", tif.edgeOk);
        end
        tif.edgeEnable    = 1'b0;
        tif.edgeChannel   = 3'd7;
        tif.patternEnable = 1'b1;
        tif.dontCare      = 6'h30;
        tif.sample        = 6'h30;
        #1;
        checks++;
        if (tif.edgeOk !== 1'b1 || tif.patternOk !== 1'b1) begin
            failures++;
            $display("FAIL sm_dc edge=%b pat=%b exp 1/1", tif.edgeOk, tif.patternOk);
        end
        tif.sample = 6'h31;
        #1;
        checks++;
        if (tif.patternOk !== 1'b0) begin
            failures++;
            $display("FAIL sm_patmiss pat=%b exp=0", tif.patternOk);
        end
        tif.activeChannels = 6'h3E;
        #1;
        checks++;
        if (tif.patternOk !== 1'b1) begin
            failures++;
            $display("FAIL sm_inactive pat=%b exp=1", tif.patternOk);
        end
        cfg_clear();
        set_pat(0, 8'h3C, 16'd0);
        cfgEdgeChannel[2:0] = 3'd7;
        do_reset();
        arm = 1'b1;
        cyc(1'b1, 8'h00);
        arm = 1'b0;
        cyc(1'b1, 8'h3D);
        cyc(1'b1, 8'h3C);
        checks++;
        if (triggered !== 1'b1 || done !== 1'b1) begin
            failures++;
            $display("FAIL pat_only trig=%b done=%b exp 1/1", triggered, done);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        arm         = 1'b0;
        disarm      = 1'b0;
        sampleValid = 1'b0;
        sample      = 8'h00;
        cfg_clear();
        test_reset();
        test_sequence();
        test_match_count();
        test_restart();
        test_abort();
        test_transition();
        test_reset_mid();
        test_edge_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
